// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Writeback-side producer for the register-file write port. ALU and LSU
//   results arrive over valid/ready channels. Each source is buffered in its
//   own DEPTH-entry FIFO. A round-robin arbiter drains the FIFO heads into
//   registered rf_we/rf_waddr/rf_wdata outputs, at most one write per cycle.
//   Results targeting x0 are accepted and then dropped.
//
//   Optional feature macro: RF_WB_PENDING_EN
//     When defined, the pending_mask output is added. It has one bit per
//     architectural register and marks every register that still has a
//     write outstanding in this block.
//
//   Widths come from `WORD_WIDTH and `RF_ADDR_WIDTH. Both have local
//   defaults when the surrounding build has not defined them.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module rf_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [`RF_ADDR_WIDTH-1:0] alu_rd,
  input  logic [`WORD_WIDTH-1:0]    alu_data,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [`RF_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [`WORD_WIDTH-1:0]    lsu_data,
  output logic                      rf_we,
  output logic [`RF_ADDR_WIDTH-1:0] rf_waddr,
  output logic [`WORD_WIDTH-1:0]    rf_wdata,
  output logic                      idle
`ifdef RF_WB_PENDING_EN
  ,
  output logic [(1<<`RF_ADDR_WIDTH)-1:0] pending_mask
`endif
);

  localparam int RW = `RF_ADDR_WIDTH;
  localparam int WW = `WORD_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // ------------------------------------------------------------------
  // Per-source FIFO storage and pointers.
  // The extra pointer MSB tells "full" apart from "empty" when the low
  // bits are equal, so all DEPTH slots are usable.
  // ------------------------------------------------------------------
  logic [RW-1:0] alu_rd_mem_r   [DEPTH];
  logic [WW-1:0] alu_data_mem_r [DEPTH];
  logic [RW-1:0] lsu_rd_mem_r   [DEPTH];
  logic [WW-1:0] lsu_data_mem_r [DEPTH];

  logic [PW-1:0] alu_wptr_r;
  logic [PW-1:0] alu_rptr_r;
  logic [PW-1:0] lsu_wptr_r;
  logic [PW-1:0] lsu_rptr_r;

  logic          alu_full_s;
  logic          alu_empty_s;
  logic          lsu_full_s;
  logic          lsu_empty_s;
  logic          alu_push_s;
  logic          lsu_push_s;

  // Arbitration state: rr_lsu_r = 1 means the LSU wins the next dual grant.
  logic          rr_lsu_r;
  logic          alu_grant_s;
  logic          lsu_grant_s;
  logic          rr_toggle_s;
  logic [RW-1:0] head_rd_s;
  logic [WW-1:0] head_data_s;

  // Registered write-port state.
  logic          rf_we_r;
  logic [RW-1:0] rf_waddr_r;
  logic [WW-1:0] rf_wdata_r;

  assign alu_empty_s = (alu_wptr_r == alu_rptr_r);
  assign lsu_empty_s = (lsu_wptr_r == lsu_rptr_r);
  assign alu_full_s  = (alu_wptr_r[AW-1:0] == alu_rptr_r[AW-1:0]) &&
                       (alu_wptr_r[AW] != alu_rptr_r[AW]);
  assign lsu_full_s  = (lsu_wptr_r[AW-1:0] == lsu_rptr_r[AW-1:0]) &&
                       (lsu_wptr_r[AW] != lsu_rptr_r[AW]);

  // Ready depends only on occupancy. A pop in the same cycle does not
  // free a slot for an incoming push.
  assign alu_ready = !alu_full_s;
  assign lsu_ready = !lsu_full_s;

  // A handshake with rd == x0 completes without touching the FIFO.
  assign alu_push_s = alu_valid && !alu_full_s && (alu_rd != {RW{1'b0}});
  assign lsu_push_s = lsu_valid && !lsu_full_s && (lsu_rd != {RW{1'b0}});

  // ALU FIFO payload write: storage needs no reset, validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (alu_push_s) begin
      alu_rd_mem_r[alu_wptr_r[AW-1:0]]   <= alu_rd;
      alu_data_mem_r[alu_wptr_r[AW-1:0]] <= alu_data;
    end
  end

  // LSU FIFO payload write: storage needs no reset, validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (lsu_push_s) begin
      lsu_rd_mem_r[lsu_wptr_r[AW-1:0]]   <= lsu_rd;
      lsu_data_mem_r[lsu_wptr_r[AW-1:0]] <= lsu_data;
    end
  end

  // FIFO pointer update: push advances wptr and grant advances rptr; wrap is modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wptr_r <= {PW{1'b0}};
      alu_rptr_r <= {PW{1'b0}};
      lsu_wptr_r <= {PW{1'b0}};
      lsu_rptr_r <= {PW{1'b0}};
    end else begin
      if (alu_push_s) begin
        alu_wptr_r <= alu_wptr_r + PTR_ONE;
      end
      if (alu_grant_s) begin
        alu_rptr_r <= alu_rptr_r + PTR_ONE;
      end
      if (lsu_push_s) begin
        lsu_wptr_r <= lsu_wptr_r + PTR_ONE;
      end
      if (lsu_grant_s) begin
        lsu_rptr_r <= lsu_rptr_r + PTR_ONE;
      end
    end
  end

  // Round-robin grant: a single non-empty FIFO wins outright; a tie goes to the rr pointer.
  always_comb begin
    alu_grant_s = 1'b0;
    lsu_grant_s = 1'b0;
    rr_toggle_s = 1'b0;
    if (!alu_empty_s && !lsu_empty_s) begin
      rr_toggle_s = 1'b1;
      if (rr_lsu_r) begin
        lsu_grant_s = 1'b1;
      end else begin
        alu_grant_s = 1'b1;
      end
    end else if (!alu_empty_s) begin
      alu_grant_s = 1'b1;
    end else if (!lsu_empty_s) begin
      lsu_grant_s = 1'b1;
    end else begin
      alu_grant_s = 1'b0;
      lsu_grant_s = 1'b0;
    end
  end

  // Head-of-line selection for the granted source.
  always_comb begin
    head_rd_s   = {RW{1'b0}};
    head_data_s = {WW{1'b0}};
    if (lsu_grant_s) begin
      head_rd_s   = lsu_rd_mem_r[lsu_rptr_r[AW-1:0]];
      head_data_s = lsu_data_mem_r[lsu_rptr_r[AW-1:0]];
    end else if (alu_grant_s) begin
      head_rd_s   = alu_rd_mem_r[alu_rptr_r[AW-1:0]];
      head_data_s = alu_data_mem_r[alu_rptr_r[AW-1:0]];
    end else begin
      head_rd_s   = {RW{1'b0}};
      head_data_s = {WW{1'b0}};
    end
  end

  // Write-port register: a grant loads the head; otherwise we drops and addr/data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {RW{1'b0}};
      rf_wdata_r <= {WW{1'b0}};
    end else if (alu_grant_s || lsu_grant_s) begin
      rf_we_r    <= 1'b1;
      rf_waddr_r <= head_rd_s;
      rf_wdata_r <= head_data_s;
    end else begin
      rf_we_r    <= 1'b0;
    end
  end

  // Round-robin pointer: starts LSU-first and flips only when both sources contend.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_lsu_r <= 1'b1;
    end else if (rr_toggle_s) begin
      rr_lsu_r <= !rr_lsu_r;
    end else begin
      rr_lsu_r <= rr_lsu_r;
    end
  end

  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign idle     = alu_empty_s && lsu_empty_s && !rf_we_r;

`ifdef RF_WB_PENDING_EN
  localparam int REGS = 1 << RW;

  logic [PW-1:0]   alu_count_s;
  logic [PW-1:0]   lsu_count_s;
  logic [AW-1:0]   alu_slot_s;
  logic [AW-1:0]   lsu_slot_s;
  logic [REGS-1:0] pend_s;

  assign alu_count_s = alu_wptr_r - alu_rptr_r;
  assign lsu_count_s = lsu_wptr_r - lsu_rptr_r;

  // Pending mask: OR together every live FIFO entry and the in-flight write; x0 is never pending.
  always_comb begin
    pend_s     = {REGS{1'b0}};
    alu_slot_s = {AW{1'b0}};
    lsu_slot_s = {AW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      alu_slot_s = alu_rptr_r[AW-1:0] + AW'(k);
      lsu_slot_s = lsu_rptr_r[AW-1:0] + AW'(k);
      pend_s[alu_rd_mem_r[alu_slot_s]] = pend_s[alu_rd_mem_r[alu_slot_s]] |
                                         (PW'(k) < alu_count_s);
      pend_s[lsu_rd_mem_r[lsu_slot_s]] = pend_s[lsu_rd_mem_r[lsu_slot_s]] |
                                         (PW'(k) < lsu_count_s);
    end
    pend_s[rf_waddr_r] = pend_s[rf_waddr_r] | rf_we_r;
    pend_s[0]          = 1'b0;
  end

  assign pending_mask = pend_s;
`endif

endmodule
